// File: rtl/network_trust_gate.sv
// network_trust_gate: forwards AXI-Stream-style frames only while the arbiter
// reports the network as trusted. The forward/drop decision is taken on the
// first beat of each frame. A mid-frame trust revocation truncates the frame
// with a zeroed beat that carries M_TLAST and M_TERR.
// Optional feature macro: NETWORK_TRUST_GATE_STATS_EN builds the saturating
// FRAMES_PASSED / FRAMES_DROPPED counters; without it both outputs read 0.
module network_trust_gate #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  TRUSTED,
  input  logic                  S_TVALID,
  output logic                  S_TREADY,
  input  logic [DATA_WIDTH-1:0] S_TDATA,
  input  logic                  S_TLAST,
  output logic                  M_TVALID,
  input  logic                  M_TREADY,
  output logic [DATA_WIDTH-1:0] M_TDATA,
  output logic                  M_TLAST,
  output logic                  M_TERR,
  output logic [CNT_WIDTH-1:0]  FRAMES_PASSED,
  output logic [CNT_WIDTH-1:0]  FRAMES_DROPPED
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   out_free;
  logic   accept;
  logic   load;
  logic   load_err;

  assign out_free = !M_TVALID || M_TREADY;
  assign accept   = S_TVALID && S_TREADY;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, upstream ready and output-register load decisions
  always_comb begin
    state_next = state;
    S_TREADY   = 1'b0;
    load       = 1'b0;
    load_err   = 1'b0;
    unique case (state)
      IDLE: begin
        S_TREADY = TRUSTED ? out_free : 1'b1;
        if (accept) begin
          if (TRUSTED) begin
            load       = 1'b1;
            state_next = S_TLAST ? IDLE : PASS;
          end else begin
            state_next = S_TLAST ? IDLE : DROP;
          end
        end
      end
      PASS: begin
        S_TREADY = out_free;
        if (accept) begin
          load = 1'b1;
          if (TRUSTED) begin
            state_next = S_TLAST ? IDLE : PASS;
          end else begin
            load_err   = 1'b1;
            state_next = S_TLAST ? IDLE : DROP;
          end
        end
      end
      DROP: begin
        S_TREADY = 1'b1;
        if (accept && S_TLAST) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Downstream output register; a truncating beat is zeroed and closes the frame
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      M_TVALID <= 1'b0;
      M_TDATA  <= '0;
      M_TLAST  <= 1'b0;
      M_TERR   <= 1'b0;
    end else if (load) begin
      M_TVALID <= 1'b1;
      M_TDATA  <= load_err ? '0 : S_TDATA;
      M_TLAST  <= S_TLAST || load_err;
      M_TERR   <= load_err;
    end else if (M_TREADY) begin
      M_TVALID <= 1'b0;
    end
  end

`ifdef NETWORK_TRUST_GATE_STATS_EN
  logic pass_inc;
  logic drop_inc;

  // A frame passes when its last beat is forwarded with trust still held
  assign pass_inc = accept && TRUSTED && S_TLAST && ((state == IDLE) || (state == PASS));
  // A frame drops when it starts untrusted or loses trust while forwarding
  assign drop_inc = accept && !TRUSTED && ((state == IDLE) || (state == PASS));

  // Saturating frame statistics
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      FRAMES_PASSED  <= '0;
      FRAMES_DROPPED <= '0;
    end else begin
      if (pass_inc && (FRAMES_PASSED != '1)) begin
        FRAMES_PASSED <= FRAMES_PASSED + CNT_WIDTH'(1);
      end
      if (drop_inc && (FRAMES_DROPPED != '1)) begin
        FRAMES_DROPPED <= FRAMES_DROPPED + CNT_WIDTH'(1);
      end
    end
  end
`else
  assign FRAMES_PASSED  = '0;
  assign FRAMES_DROPPED = '0;
`endif

endmodule

// File: tb/tb_network_trust_gate.sv
// Directed bench for network_trust_gate with a scoreboard of expected
// downstream beats. Expected counter values follow the build: with
// NETWORK_TRUST_GATE_STATS_EN the bench models 2-bit saturating counters,
// otherwise both counters are expected to read 0.
module tb_network_trust_gate;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 2;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          TRUSTED;
  logic          S_TVALID;
  logic          S_TREADY;
  logic [DW-1:0] S_TDATA;
  logic          S_TLAST;
  logic          M_TVALID;
  logic          M_TREADY;
  logic [DW-1:0] M_TDATA;
  logic          M_TLAST;
  logic          M_TERR;
  logic [CW-1:0] FRAMES_PASSED;
  logic [CW-1:0] FRAMES_DROPPED;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          err;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    exp_passed = 0;
  int    exp_dropped = 0;

  network_trust_gate #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RESET(RESET), .TRUSTED(TRUSTED),
    .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TDATA(S_TDATA), .S_TLAST(S_TLAST),
    .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA), .M_TLAST(M_TLAST),
    .M_TERR(M_TERR), .FRAMES_PASSED(FRAMES_PASSED), .FRAMES_DROPPED(FRAMES_DROPPED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic last, input logic err);
    beat_t b;
    b.data = d;
    b.last = last;
    b.err  = err;
    exp_q.push_back(b);
  endtask

  // Saturating counter model for the configured build
  function automatic int sat(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic chk_counters(input string tag);
`ifdef NETWORK_TRUST_GATE_STATS_EN
    chk({tag, "_passed"}, 64'(FRAMES_PASSED), 64'(sat(exp_passed)));
    chk({tag, "_dropped"}, 64'(FRAMES_DROPPED), 64'(sat(exp_dropped)));
`else
    chk({tag, "_passed"}, 64'(FRAMES_PASSED), 64'd0);
    chk({tag, "_dropped"}, 64'(FRAMES_DROPPED), 64'd0);
`endif
  endtask

  // Present one beat and hold it until accepted; returns 1ns after the accepting edge
  task automatic send(input logic [DW-1:0] d, input logic last, input logic tr);
    int n;
    S_TVALID = 1'b1;
    S_TDATA  = d;
    S_TLAST  = last;
    TRUSTED  = tr;
    n = 0;
    @(negedge CLK);
    while (!S_TREADY && n < 50) begin
      n++;
      @(negedge CLK);
    end
    if (!S_TREADY) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=busy expected=accept data=%0h", d);
    end
    @(posedge CLK);
    #1;
    S_TVALID = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Scoreboard: every completed downstream handshake must match the next expected beat
  always @(negedge CLK) begin
    if (!RESET && M_TVALID && M_TREADY) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_beat observed=%0h expected=none", M_TDATA);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat", {31'd0, M_TDATA, M_TLAST}, {31'd0, e.data, e.last});
        chk("beat_err", 64'(M_TERR), 64'(e.err));
      end
    end
  end

  initial begin
    RESET    = 1'b1;
    TRUSTED  = 1'b1;
    S_TVALID = 1'b0;
    S_TDATA  = '0;
    S_TLAST  = 1'b0;
    M_TREADY = 1'b1;
    idle_cycles(3);
    RESET = 1'b0;
    #1;

    // Reset state
    chk("rst_tvalid", 64'(M_TVALID), 64'd0);
    chk("rst_tdata", 64'(M_TDATA), 64'd0);
    chk("rst_tlast", 64'(M_TLAST), 64'd0);
    chk("rst_terr", 64'(M_TERR), 64'd0);
    chk("rst_tready", 64'(S_TREADY), 64'd1);
    chk_counters("rst");

    // Trusted 4-beat frame, one cycle latency
    push(32'h11, 1'b0, 1'b0);
    push(32'h22, 1'b0, 1'b0);
    push(32'h33, 1'b0, 1'b0);
    push(32'h44, 1'b1, 1'b0);
    send(32'h11, 1'b0, 1'b1);
    chk("lat_valid", 64'(M_TVALID), 64'd1);
    chk("lat_data", 64'(M_TDATA), 64'h11);
    send(32'h22, 1'b0, 1'b1);
    send(32'h33, 1'b0, 1'b1);
    send(32'h44, 1'b1, 1'b1);
    exp_passed++;
    chk_counters("pass4");
    idle_cycles(2);
    chk("pass4_drained", 64'(M_TVALID), 64'd0);

    // Untrusted 3-beat frame; trust rising mid-frame forwards nothing
    send(32'hD1, 1'b0, 1'b0);
    chk("drop_none1", 64'(M_TVALID), 64'd0);
    send(32'hD2, 1'b0, 1'b1);
    chk("drop_none2", 64'(M_TVALID), 64'd0);
    send(32'hD3, 1'b1, 1'b1);
    chk("drop_none3", 64'(M_TVALID), 64'd0);
    exp_dropped++;
    chk_counters("drop3");

    // Revocation on beat 2: truncated with zeroed error beat, rest discarded
    push(32'h01, 1'b0, 1'b0);
    push(32'h00, 1'b1, 1'b1);
    send(32'h01, 1'b0, 1'b1);
    send(32'hAA, 1'b0, 1'b0);
    chk("rev_terr", 64'(M_TERR), 64'd1);
    send(32'hB3, 1'b0, 1'b1);
    send(32'hB4, 1'b0, 1'b1);
    send(32'hB5, 1'b1, 1'b1);
    exp_dropped++;
    chk("rev_idle", 64'(M_TVALID), 64'd0);
    chk_counters("rev");

    // Backpressure: pending 0x5A held, upstream stalled, then drain and accept together
    M_TREADY = 1'b0;
    push(32'h5A, 1'b0, 1'b0);
    push(32'h5B, 1'b1, 1'b0);
    send(32'h5A, 1'b0, 1'b1);
    S_TVALID = 1'b1;
    S_TDATA  = 32'h5B;
    S_TLAST  = 1'b1;
    TRUSTED  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_stall", 64'(S_TREADY), 64'd0);
      chk("bp_hold", {31'd0, M_TDATA, M_TVALID}, {31'd0, 32'h5A, 1'b1});
    end
    @(posedge CLK);
    #1;
    M_TREADY = 1'b1;
    @(negedge CLK);
    chk("bp_release", 64'(S_TREADY), 64'd1);
    @(posedge CLK);
    #1;
    S_TVALID = 1'b0;
    chk("bp_next", {31'd0, M_TDATA, M_TLAST}, {31'd0, 32'h5B, 1'b1});
    exp_passed++;
    chk_counters("bp");
    idle_cycles(2);

    // Reset mid-frame clears the output; next beat starts a new frame
    M_TREADY = 1'b0;
    send(32'h77, 1'b0, 1'b1);
    S_TVALID = 1'b1;
    S_TDATA  = 32'h78;
    S_TLAST  = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(M_TVALID), 64'd0);
    S_TVALID = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    exp_passed = 0;
    exp_dropped = 0;
    M_TREADY = 1'b1;
    send(32'h79, 1'b1, 1'b0);
    exp_dropped++;
    chk("rst_new_drop", 64'(M_TVALID), 64'd0);
    chk_counters("rst_new");

    // Five more dropped frames: counter saturates, no wrap
    for (int i = 0; i < 5; i++) begin
      send(32'hC0 + 32'(i), 1'b1, 1'b0);
      exp_dropped++;
      chk_counters("sat");
    end
    idle_cycles(3);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/network_trust_gate.md
# network_trust_gate

Downstream consumer of the network arbiter main logic's TRUSTED output. The block sits between the network stream source and the consumer domain, and forwards each frame only while the arbiter reports the network as trusted. The forward/drop decision is made per frame on its first beat. Frames that start while the network is untrusted are consumed and discarded, and a frame whose trust is revoked mid-flight is truncated with an error marker.

## Interface
Parameters:
- DATA_WIDTH, 32, stream data width in bits
- CNT_WIDTH, 16, width of statistics counters

Ports:
- CLK  in  1  clock; all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- TRUSTED  in  1  trust flag from network arbiter main logic; 1 = trusted
- S_TVALID  in  1  upstream beat valid
- S_TREADY  out  1  upstream beat accepted when S_TVALID && S_TREADY
- S_TDATA  in  DATA_WIDTH  upstream beat data
- S_TLAST  in  1  upstream last beat of frame
- M_TVALID  out  1  downstream beat valid (registered)
- M_TREADY  in  1  downstream ready
- M_TDATA  out  DATA_WIDTH  downstream data (registered)
- M_TLAST  out  1  downstream last beat (registered)
- M_TERR  out  1  frame truncated by trust revocation; only ever set with M_TLAST
- FRAMES_PASSED  out  CNT_WIDTH  frames forwarded complete (see Configuration)
- FRAMES_DROPPED  out  CNT_WIDTH  frames discarded or truncated (see Configuration)

## Operation
- FSM states:
  - IDLE: between frames
  - PASS: forwarding a frame
  - DROP: discarding the rest of a frame
- out_free = !M_TVALID || M_TREADY.
- S_TREADY is combinational:
  - IDLE: TRUSTED ? out_free : 1
  - PASS: out_free
  - DROP: 1
- IDLE, beat accepted with TRUSTED=1:
  - Beat is loaded into the output register.
  - Next state is PASS if S_TLAST=0, else stays IDLE.
- IDLE, beat accepted with TRUSTED=0:
  - Beat is discarded.
  - Next state is DROP if S_TLAST=0, else stays IDLE.
  - Frame counts as dropped.
- PASS, beat accepted with TRUSTED=1:
  - Beat is forwarded unchanged.
  - On S_TLAST the state returns to IDLE and the frame counts as passed.
- PASS, beat accepted with TRUSTED=0 (revocation mid-frame):
  - The beat is forwarded with M_TDATA forced to 0, M_TLAST=1 and M_TERR=1.
  - Next state is DROP if S_TLAST=0, else IDLE.
  - Frame counts as dropped, not passed.
- DROP: every beat is accepted and discarded. On S_TLAST the state returns to IDLE. TRUSTED is ignored.
- No beat is ever forwarded from a frame whose first beat was accepted with TRUSTED=0, even if TRUSTED rises mid-frame.
- Frames are never reordered or merged. The M side always sees well-formed frames terminated by M_TLAST.

## Timing
- Reset values: M_TVALID=0, M_TDATA=0, M_TLAST=0, M_TERR=0, FRAMES_PASSED=0, FRAMES_DROPPED=0, FSM=IDLE. S_TREADY follows the IDLE rule immediately after reset.
- Latency: a beat accepted in cycle N appears on M_* in cycle N+1.
- Throughput: one beat per cycle while M_TREADY=1.
- M_* outputs are held stable while M_TVALID && !M_TREADY.
- M_TVALID clears on a cycle in which M_TREADY=1 and no new beat is accepted.
- TRUSTED is sampled only in the cycle a beat is accepted. Changes with no handshake have no effect.
- Reset asserted mid-frame: output register is cleared and the FSM goes to IDLE. The next beat after reset is treated as a frame start.
- Counters saturate at all-ones and do not wrap.

## Configuration
- Macro: NETWORK_TRUST_GATE_STATS_EN.
- Defined: FRAMES_PASSED and FRAMES_DROPPED are CNT_WIDTH-bit saturating registers.
  - Each increments one cycle after the deciding handshake.
  - Both are cleared only by RESET.
- Undefined: no counter registers are built. Both outputs are tied to 0.
- Forwarding behaviour is identical in both builds.

## Test plan
- TRUSTED=1, 4-beat frame 0x11..0x44, M_TREADY=1 → M_* carries 0x11..0x44 one cycle later with M_TLAST on 0x44 and M_TERR=0; FRAMES_PASSED=1.
- TRUSTED=0, 3-beat frame → S_TREADY=1 on every beat, M_TVALID stays 0, FRAMES_DROPPED=1. Raising TRUSTED on beat 2 still forwards nothing.
- TRUSTED=1, 5-beat frame, TRUSTED drops while beat 2 (0xAA) is accepted → M_* emits beat 1, then 0x00 with M_TLAST=1 and M_TERR=1. Beats 3-5 are discarded; FRAMES_DROPPED=1, FRAMES_PASSED=0.
- TRUSTED=1, M_TREADY=0 for 3 cycles with beat 0x5A pending → M_TDATA holds 0x5A and S_TREADY=0. M_TREADY=1 drains 0x5A, and the next beat is accepted in the same cycle.
- RESET pulsed during beat 2 of a trusted frame → M_TVALID=0 immediately. The next beat (TRUSTED=0, S_TLAST=1) is dropped as a new single-beat frame.
- Built with NETWORK_TRUST_GATE_STATS_EN and CNT_WIDTH=2, 5 dropped frames → FRAMES_DROPPED=3, no wrap. Built without the macro → both counters read 0.
